// File: rtl/snn_mem_pkg.sv
// Shared types and address packing for the IF network weight-memory port.
package snn_mem_pkg;

  localparam int LAYER_ADDR_W  = 32;
  localparam int NEURON_ADDR_W = 28;
  localparam int WEIGHT_ADDR_W = 10;
  localparam int LAYER_FIELD_W  = LAYER_ADDR_W - NEURON_ADDR_W;
  localparam int NEURON_FIELD_W = NEURON_ADDR_W - WEIGHT_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_VERIFY,
    S_DRAIN,
    S_FINISH
  } loader_state_t;

  function automatic logic [LAYER_ADDR_W-1:0] pack_weight_addr(
    input logic [LAYER_FIELD_W-1:0]  layer,
    input logic [NEURON_FIELD_W-1:0] neuron,
    input logic [WEIGHT_ADDR_W-1:0]  weight
  );
    return {layer, neuron, weight};
  endfunction

endpackage

// File: rtl/weight_index_counter.sv
// Nested weight/neuron index counter; wraps to 0/0 after the last entry.
module weight_index_counter #(
  parameter int NUM_NEURONS = 1,
  parameter int NUM_WEIGHTS = 5,
  parameter int NIW = 1,
  parameter int WIW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           inc,
  output logic [NIW-1:0] neuron_idx,
  output logic [WIW-1:0] weight_idx,
  output logic           last
);

  localparam logic [NIW-1:0] LAST_N = NIW'(NUM_NEURONS - 1);
  localparam logic [WIW-1:0] LAST_W = WIW'(NUM_WEIGHTS - 1);

  assign last = (neuron_idx == LAST_N) && (weight_idx == LAST_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neuron_idx <= '0;
      weight_idx <= '0;
    end else if (clr) begin
      neuron_idx <= '0;
      weight_idx <= '0;
    end else if (inc) begin
      if (weight_idx == LAST_W) begin
        weight_idx <= '0;
        neuron_idx <= (neuron_idx == LAST_N) ? '0 : neuron_idx + 1'b1;
      end else begin
        weight_idx <= weight_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_weight_loader.sv
// Streams one layer's weight table into the IF network memory and optionally
// reads it back, comparing write and readback checksums.
module if_weight_loader
  import snn_mem_pkg::*;
#(
  parameter int WEIGHT_SIZE       = 32,
  parameter int LAYER_ADDR_WIDTH  = LAYER_ADDR_W,
  parameter int NEURON_ADDR_WIDTH = NEURON_ADDR_W,
  parameter int WEIGHT_ADDR_WIDTH = WEIGHT_ADDR_W,
  parameter int NUM_NEURONS       = 1,
  parameter int NUM_WEIGHTS       = 5,
  parameter int RD_LATENCY        = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic                                          verify_en,
  input  logic [LAYER_ADDR_WIDTH-NEURON_ADDR_WIDTH-1:0] layer_sel,
  input  logic                                          w_valid,
  input  logic [WEIGHT_SIZE-1:0]                        w_data,
  output logic                                          w_ready,
  output logic [LAYER_ADDR_WIDTH-1:0]                   mem_addr,
  output logic [WEIGHT_SIZE-1:0]                        mem_din,
  output logic                                          mem_wen,
  input  logic [WEIGHT_SIZE-1:0]                        mem_dout,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          error
);

  localparam int LW  = LAYER_ADDR_WIDTH - NEURON_ADDR_WIDTH;
  localparam int NFW = NEURON_ADDR_WIDTH - WEIGHT_ADDR_WIDTH;
  localparam int NIW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int WIW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;

  loader_state_t state, next_state;

  logic [LW-1:0]          layer_q;
  logic                   verify_en_q;
  logic [WEIGHT_SIZE-1:0] wsum, rsum;
  logic [RD_LATENCY:0]    vld_pipe;
  logic [NIW-1:0]         neuron_idx;
  logic [WIW-1:0]         weight_idx;
  logic                   idx_last, cnt_clr, cnt_inc, hs;
  logic [LAYER_ADDR_WIDTH-1:0] addr_cur;

  weight_index_counter #(
    .NUM_NEURONS(NUM_NEURONS),
    .NUM_WEIGHTS(NUM_WEIGHTS),
    .NIW(NIW),
    .WIW(WIW)
  ) u_idx (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(cnt_inc),
    .neuron_idx(neuron_idx),
    .weight_idx(weight_idx),
    .last(idx_last)
  );

  assign addr_cur = LAYER_ADDR_WIDTH'(pack_weight_addr(layer_q, NFW'(neuron_idx),
                                                       WEIGHT_ADDR_WIDTH'(weight_idx)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    hs         = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_clr    = 1'b1;
          next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        hs = w_valid & w_ready;
        if (hs) begin
          cnt_inc = 1'b1;
          if (idx_last) next_state = verify_en_q ? S_VERIFY : S_FINISH;
        end
      end
      S_VERIFY: begin
        cnt_inc = 1'b1;
        if (idx_last) next_state = S_DRAIN;
      end
      // the oldest tag is consumed on this edge, so only younger ones hold us here
      S_DRAIN: begin
        if (vld_pipe[RD_LATENCY-1:0] == '0) next_state = S_FINISH;
      end
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ready     <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_wen     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      layer_q     <= '0;
      verify_en_q <= 1'b0;
      wsum        <= '0;
      rsum        <= '0;
      vld_pipe    <= '0;
    end else begin
      mem_wen  <= hs;
      w_ready  <= (next_state == S_WRITE);
      busy     <= (next_state != S_IDLE);
      done     <= (state == S_FINISH);
      vld_pipe <= {vld_pipe[RD_LATENCY-1:0], state == S_VERIFY};
      if (hs) begin
        mem_din  <= w_data;
        mem_addr <= addr_cur;
        wsum     <= wsum + w_data;
      end
      if (state == S_VERIFY) mem_addr <= addr_cur;
      if (vld_pipe[RD_LATENCY]) rsum <= rsum + mem_dout;
      if (state == S_FINISH) error <= verify_en_q && (rsum != wsum);
      if (state == S_IDLE && start) begin
        layer_q     <= layer_sel;
        verify_en_q <= verify_en;
        wsum        <= '0;
        rsum        <= '0;
        error       <= 1'b0;
      end
    end
  end

endmodule
